// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3x3 convolution datapath: loads activation/weight pairs into
// the dual-port BRAM, replays both regions into the shift windows and captures the sum.
module conv_seq_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int N_TAPS  = 27,
    parameter int W_BASE  = 27,
    parameter int RD_LAT  = 2,
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_wgt,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              wren_a,
    output logic              wren_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              shift_en,
    input  logic [DATA_W-1:0] result_in,
    output logic [DATA_W-1:0] result_out,
    output logic              result_valid,
    output logic              busy,
    output logic              loaded,
    output logic              run_err
);

    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int ACC_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    localparam logic [ADDR_W-1:0] ADDR_PARK = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] W_BASE_A  = ADDR_W'(W_BASE);
    localparam logic [CNT_W-1:0]  LAST_TAP  = CNT_W'(N_TAPS - 1);
    localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(ADD_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, DRAIN, ACC} state_t;

    state_t            state;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [ACC_W-1:0]  acc_cnt;

    // Stage 0 travels with the issued address; the last stage lines up with q_a/q_b.
    logic [RD_LAT:0]   vld_pipe;

    assign shift_en = vld_pipe[RD_LAT];

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            load_cnt     <= '0;
            fetch_cnt    <= '0;
            acc_cnt      <= '0;
            addr_a       <= ADDR_PARK;
            addr_b       <= ADDR_PARK;
            wren_a       <= 1'b0;
            wren_b       <= 1'b0;
            data_a       <= '0;
            data_b       <= '0;
            in_ready     <= 1'b0;
            vld_pipe     <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            run_err      <= 1'b0;
            busy         <= 1'b0;
            loaded       <= 1'b0;
        end else begin
            vld_pipe     <= {vld_pipe[RD_LAT-1:0], state == FETCH};
            result_valid <= 1'b0;
            run_err      <= 1'b0;
            wren_a       <= 1'b0;
            wren_b       <= 1'b0;

            case (state)
                IDLE: begin
                    addr_a <= ADDR_PARK;
                    addr_b <= ADDR_PARK;
                    if (cmd_load) begin
                        state    <= LOAD;
                        load_cnt <= '0;
                        loaded   <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (cmd_run) begin
                        if (loaded) begin
                            state     <= FETCH;
                            fetch_cnt <= '0;
                            busy      <= 1'b1;
                        end else begin
                            run_err <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (in_valid && in_ready) begin
                        wren_a   <= 1'b1;
                        wren_b   <= 1'b1;
                        addr_a   <= ADDR_W'(load_cnt);
                        addr_b   <= W_BASE_A + ADDR_W'(load_cnt);
                        data_a   <= in_act;
                        data_b   <= in_wgt;
                        load_cnt <= load_cnt + CNT_W'(1);
                        if (load_cnt == LAST_TAP) begin
                            in_ready <= 1'b0;
                            loaded   <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end

                FETCH: begin
                    addr_a    <= ADDR_W'(fetch_cnt);
                    addr_b    <= W_BASE_A + ADDR_W'(fetch_cnt);
                    fetch_cnt <= fetch_cnt + CNT_W'(1);
                    if (fetch_cnt == LAST_TAP) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    addr_a <= ADDR_PARK;
                    addr_b <= ADDR_PARK;
                    // Only the final shift remains in flight, so the tree starts settling next.
                    if (vld_pipe[RD_LAT-1:0] == '0) begin
                        state   <= ACC;
                        acc_cnt <= '0;
                    end
                end

                ACC: begin
                    if (acc_cnt == ACC_LAST) begin
                        result_out   <= result_in;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: BRAM (RD_LAT = 2) and MAC-tree models, with scoreboard
// queues for expected write beats and expected captured results.
module tb_conv_seq_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 6;
    localparam int N_TAPS  = 27;
    localparam int W_BASE  = 27;
    localparam int RD_LAT  = 2;
    localparam int ADD_LAT = 1;
    localparam logic [ADDR_W-1:0] PARK = 6'd63;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
    } wr_t;

    logic              clk = 1'b0;
    logic              RESET_N = 1'b1;
    logic              cmd_load = 1'b0;
    logic              cmd_run = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_act = '0;
    logic [DATA_W-1:0] in_wgt = '0;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              wren_a, wren_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              shift_en;
    logic [DATA_W-1:0] result_in;
    logic [DATA_W-1:0] result_out;
    logic              result_valid, busy, loaded, run_err;

    int checks = 0;
    int errors = 0;
    wr_t               wr_q[$];
    logic [DATA_W-1:0] res_q[$];
    logic [DATA_W-1:0] exp_result = '0;
    logic [DATA_W-1:0] last_result = '0;

    conv_seq_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_TAPS(N_TAPS),
        .W_BASE(W_BASE), .RD_LAT(RD_LAT), .ADD_LAT(ADD_LAT)
    ) dut (
        .clk(clk), .RESET_N(RESET_N), .cmd_load(cmd_load), .cmd_run(cmd_run),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .addr_a(addr_a), .addr_b(addr_b), .wren_a(wren_a), .wren_b(wren_b),
        .data_a(data_a), .data_b(data_b), .shift_en(shift_en), .result_in(result_in),
        .result_out(result_out), .result_valid(result_valid), .busy(busy),
        .loaded(loaded), .run_err(run_err)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM with two-cycle read latency feeding a multiply-accumulate tree.
    logic [DATA_W-1:0] mem [0:63];
    logic [DATA_W-1:0] ra1, rb1, q_a, q_b, acc;

    always @(posedge clk) begin
        if (wren_a) mem[addr_a] <= data_a;
        if (wren_b) mem[addr_b] <= data_b;
        ra1 <= mem[addr_a];
        rb1 <= mem[addr_b];
        q_a <= ra1;
        q_b <= rb1;
        if (cmd_run) acc <= '0;
        else if (shift_en) acc <= acc + q_a * q_b;
    end

    assign result_in = acc;

    task automatic test_reset();
        RESET_N = 1'b1;
        repeat (2) @(posedge clk);
        #3 RESET_N = 1'b0;
        #1;
        checks++;
        if (addr_a !== PARK || addr_b !== PARK || wren_a !== 1'b0 || wren_b !== 1'b0 ||
            data_a !== '0 || data_b !== '0 || in_ready !== 1'b0 || shift_en !== 1'b0 ||
            result_valid !== 1'b0 || run_err !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0 ||
            result_out !== '0)
            begin
                errors++;
                $display("[TB] FAIL reset_values: addr_a=%0d addr_b=%0d wren=%b%b data=%0d/%0d rdy=%b sh=%b rv=%b err=%b busy=%b loaded=%b res=%0d, want 63 63 00 0/0 and all flags 0",
                         addr_a, addr_b, wren_a, wren_b, data_a, data_b, in_ready, shift_en,
                         result_valid, run_err, busy, loaded, result_out);
            end
        repeat (2) @(posedge clk);
        @(negedge clk) RESET_N = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || addr_a !== PARK || addr_b !== PARK || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: busy=%b addr_a=%0d addr_b=%0d in_ready=%b, want 0 63 63 0",
                     busy, addr_a, addr_b, in_ready);
        end
    endtask

    task automatic test_run_err();
        cmd_run = 1'b1;
        @(posedge clk); #1;
        cmd_run = 1'b0;
        checks++;
        if (run_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_err_pulse: run_err=%b busy=%b, want 1 0", run_err, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (run_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_err_single: run_err=%b busy=%b, want 0 0", run_err, busy);
        end
    endtask

    task automatic test_load(input int scale, input bit gaps, input bit with_run);
        int  k = 0;
        int  cyc = 0;
        int  writes = 0;
        bit  beat;
        wr_t exp_w;
        wr_t got_w;
        wr_q.delete();
        exp_result = '0;
        cmd_load = 1'b1;
        cmd_run  = with_run;
        @(posedge clk); #1;
        cmd_load = 1'b0;
        cmd_run  = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || loaded !== 1'b0 || run_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_entry: busy=%b in_ready=%b loaded=%b run_err=%b, want 1 1 0 0",
                     busy, in_ready, loaded, run_err);
        end
        while (k < N_TAPS && cyc < 200) begin
            in_valid = !gaps || (cyc % 2 == 0);
            in_act   = DATA_W'(scale * (k + 1));
            in_wgt   = 16'd1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load_ready: k=%0d in_ready=%b, want 1", k, in_ready);
            end
            beat = in_valid && in_ready;
            if (beat) begin
                wr_q.push_back('{ADDR_W'(k), ADDR_W'(W_BASE + k), in_act, in_wgt});
                exp_result = exp_result + in_act * in_wgt;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
            in_valid = 1'b0;
            checks++;
            if (wren_a !== beat || wren_b !== beat) begin
                errors++;
                $display("[TB] FAIL load_wren: cycle %0d wren_a=%b wren_b=%b, want %b", cyc, wren_a, wren_b, beat);
            end
            if (beat) begin
                exp_w = wr_q.pop_front();
                got_w = '{addr_a, addr_b, data_a, data_b};
                writes++;
                checks++;
                if (got_w !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL load_write: got a=%0d b=%0d da=%0d db=%0d, want a=%0d b=%0d da=%0d db=%0d",
                             got_w.a, got_w.b, got_w.da, got_w.db, exp_w.a, exp_w.b, exp_w.da, exp_w.db);
                end
            end
        end
        checks++;
        if (k != N_TAPS || writes != N_TAPS || wr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL load_count: beats=%0d writes=%0d pending=%0d, want 27 27 0", k, writes, wr_q.size());
        end
        checks++;
        if (in_ready !== 1'b0 || loaded !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_done: in_ready=%b loaded=%b busy=%b, want 0 1 0", in_ready, loaded, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (wren_a !== 1'b0 || wren_b !== 1'b0 || addr_a !== PARK || addr_b !== PARK) begin
            errors++;
            $display("[TB] FAIL load_park: wren=%b%b addr_a=%0d addr_b=%0d, want 00 63 63",
                     wren_a, wren_b, addr_a, addr_b);
        end
    endtask

    task automatic test_run();
        int first = -1;
        int last = -1;
        int nshift = 0;
        int rv_cyc = -1;
        int nrv = 0;
        logic [DATA_W-1:0] exp_r;
        cmd_run = 1'b1;
        @(posedge clk); #1;
        cmd_run = 1'b0;
        res_q.push_back(exp_result);
        checks++;
        if (busy !== 1'b1 || run_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_start: busy=%b run_err=%b, want 1 0", busy, run_err);
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (shift_en === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                nshift++;
            end
            if (cyc <= N_TAPS) begin
                checks++;
                if (addr_a !== ADDR_W'(cyc - 1) || addr_b !== ADDR_W'(W_BASE + cyc - 1) || wren_a !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL run_addr: cycle %0d addr_a=%0d addr_b=%0d wren_a=%b, want %0d %0d 0",
                             cyc, addr_a, addr_b, wren_a, cyc - 1, W_BASE + cyc - 1);
                end
            end
            if (result_valid === 1'b1) begin
                if (rv_cyc < 0) rv_cyc = cyc;
                nrv++;
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL run_result_extra: result_valid at cycle %0d with nothing expected", cyc);
                end else begin
                    exp_r = res_q.pop_front();
                    if (result_out !== exp_r) begin
                        errors++;
                        $display("[TB] FAIL run_result: result_out=%0d, want %0d", result_out, exp_r);
                    end
                end
            end
        end
        checks++;
        if (first != 3 || last != 29 || nshift != 27) begin
            errors++;
            $display("[TB] FAIL run_shift: first=%0d last=%0d count=%0d, want 3 29 27", first, last, nshift);
        end
        checks++;
        if (rv_cyc != 31 || nrv != 1 || res_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL run_valid: cycle=%0d pulses=%0d pending=%0d, want 31 1 0", rv_cyc, nrv, res_q.size());
        end
        res_q.delete();
        checks++;
        if (busy !== 1'b0 || loaded !== 1'b1 || addr_a !== PARK || addr_b !== PARK || result_out !== exp_result) begin
            errors++;
            $display("[TB] FAIL run_end: busy=%b loaded=%b addr_a=%0d addr_b=%0d result_out=%0d, want 0 1 63 63 %0d",
                     busy, loaded, addr_a, addr_b, result_out, exp_result);
        end
        last_result = exp_result;
    endtask

    task automatic test_result_hold();
        checks++;
        if (result_out !== last_result) begin
            errors++;
            $display("[TB] FAIL result_hold: result_out=%0d, want %0d", result_out, last_result);
        end
    endtask

    task automatic test_reset_abort();
        int nrv = 0;
        int nsh = 0;
        cmd_run = 1'b1;
        @(posedge clk); #1;
        cmd_run = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (shift_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pre: shift_en=%b busy=%b at fetch cycle 10, want 1 1", shift_en, busy);
        end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (shift_en !== 1'b0 || loaded !== 1'b0 || busy !== 1'b0 || addr_a !== PARK ||
            addr_b !== PARK || result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_reset: shift_en=%b loaded=%b busy=%b addr_a=%0d addr_b=%0d rv=%b, want 0 0 0 63 63 0",
                     shift_en, loaded, busy, addr_a, addr_b, result_valid);
        end
        @(negedge clk) RESET_N = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid === 1'b1) nrv++;
            if (shift_en === 1'b1) nsh++;
        end
        checks++;
        if (nrv != 0 || nsh != 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: result_valid pulses=%0d shift_en cycles=%0d, want 0 0", nrv, nsh);
        end
        test_run_err();
    endtask

    initial begin
        test_reset();
        test_run_err();
        test_load(1, 1'b0, 1'b1);
        test_run();
        test_run();
        test_load(2, 1'b1, 1'b0);
        test_result_hold();
        test_run();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for the 3x3x3 convolution datapath.
- Loads 27 activations and 27 weights into the dual-port 64x16 BRAM: activations at addresses 0..26, weights at 27..53.
- Replays both regions into the 432-bit activation and weight shift windows, waits for the adder tree, then captures the summed 16-bit result.
- Sits between the host-side command/stream interface and the BRAM, window registers and MAC tree.

Parameters:
- DATA_W, 16, word width of activations, weights and result.
- ADDR_W, 6, BRAM address width.
- N_TAPS, 27, words per window (3 channels x 9 taps).
- W_BASE, 27, first weight address.
- RD_LAT, 2, BRAM read latency in cycles (address to q valid).
- ADD_LAT, 1, cycles from the last shift until result_in is stable.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- cmd_load  in  1  one-cycle pulse: start the load phase.
- cmd_run  in  1  one-cycle pulse: start fetch and compute.
- in_valid  in  1  activation/weight pair present.
- in_ready  out  1  controller accepts the pair.
- in_act  in  DATA_W  activation word.
- in_wgt  in  DATA_W  weight word.
- addr_a  out  ADDR_W  BRAM port A address (activation region).
- addr_b  out  ADDR_W  BRAM port B address (weight region).
- wren_a  out  1  port A write enable.
- wren_b  out  1  port B write enable.
- data_a  out  DATA_W  port A write data.
- data_b  out  DATA_W  port B write data.
- shift_en  out  1  window registers shift in q_a/q_b this cycle.
- result_in  in  DATA_W  adder-tree output.
- result_out  out  DATA_W  captured result.
- result_valid  out  1  one-cycle pulse when result_out updates.
- busy  out  1  high in every state except IDLE.
- loaded  out  1  BRAM holds a complete 27-pair set.
- run_err  out  1  one-cycle pulse: cmd_run rejected.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - State IDLE; all counters 0.
  - addr_a = addr_b = all-ones (63); wren_a, wren_b, data_a, data_b = 0.
  - in_ready, shift_en, result_valid, run_err, busy, loaded = 0; result_out = 0.
  - The read-valid delay line is cleared.
  - Reset mid-operation aborts the operation and clears loaded.
- States: IDLE, LOAD, FETCH, DRAIN, ACC.
- IDLE:
  - Addresses parked at all-ones; write enables 0.
  - cmd_load -> LOAD, load count k = 0, loaded cleared.
  - cmd_run with loaded = 1 -> FETCH, fetch count = 0.
  - cmd_run with loaded = 0 -> run_err pulses; state stays IDLE.
  - cmd_load and cmd_run in the same cycle: load wins; run is dropped without run_err.
- LOAD:
  - in_ready = 1.
  - On each in_valid && in_ready beat, registered outputs for the next cycle: wren_a = wren_b = 1, addr_a = k, addr_b = W_BASE + k, data_a = in_act, data_b = in_wgt; then k++.
  - A cycle with no beat drives both write enables to 0.
  - On the beat with k = N_TAPS-1: in_ready drops next cycle, loaded = 1, state returns to IDLE.
  - Back-to-back beats must sustain 1 pair per cycle.
- FETCH:
  - Write enables 0.
  - In FETCH cycle j (j = 0..N_TAPS-1): addr_a = j, addr_b = W_BASE + j.
  - A 1-bit valid enters a RD_LAT-deep delay line each FETCH cycle; shift_en is the delay-line output.
  - After j = N_TAPS-1 -> DRAIN, with addresses parked at all-ones.
- DRAIN:
  - Stays until the delay line is empty.
  - Exactly N_TAPS shift_en cycles occur per run, contiguous.
- ACC:
  - Waits ADD_LAT cycles after the last shift_en.
  - Then captures result_in into result_out, pulses result_valid for one cycle, returns to IDLE.
  - loaded stays 1, so repeated runs reuse the BRAM contents.
- Timing, with cmd_run sampled on edge 0 and default parameters:
  - First address on cycle 1.
  - shift_en on cycles 3..29.
  - result_valid on cycle 31 (N_TAPS + RD_LAT + ADD_LAT + 1).
- Commands arriving while busy = 1 are ignored; run_err is not pulsed.
- Address arithmetic is modulo 2^ADDR_W. With the defaults W_BASE + N_TAPS - 1 = 53 < 63, so the regions never wrap.
- result_out holds its value until the next capture; it is unaffected by a later cmd_load.

Test Plan:
- Reset then idle: RESET_N low mid-cycle -> outputs at reset values immediately; addr_a = addr_b = 63, busy = 0, loaded = 0.
- Load 27 pairs back-to-back with in_act = k+1, in_wgt = 1 -> wren high 27 cycles, addr_a 0..26, addr_b 27..53, loaded = 1, in_ready low afterwards.
- Load with in_valid toggling every other cycle -> still exactly 27 writes with correct addresses; wren low on gap cycles.
- Run after load, with BRAM model RD_LAT = 2 and tree returning 378 -> 27 contiguous shift_en on cycles 3..29, result_valid on cycle 31, result_out = 378.
- cmd_run before any load -> run_err pulse, busy stays 0. cmd_load and cmd_run in the same cycle -> LOAD entered, no run_err.
- RESET_N pulsed at FETCH cycle 10 -> shift_en stops immediately, loaded = 0, no result_valid; a following cmd_run pulses run_err.
